// File: rtl/obi_cmd_mgr_pkg.sv
// Shared types for the OBI command manager: transaction id width, response FIFO entry,
// and the default OBI request/response structs used when no bus types are supplied.
package obi_cmd_mgr_pkg;

  localparam int unsigned AidW = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [AidW-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_default_t;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            err;
    logic [AidW-1:0] rid;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_default_t;

endpackage

// File: rtl/obi_cmd_mgr_rsp_fifo.sv
// In-order response buffer: synchronous FIFO of rsp_entry_t with outputs taken straight
// from storage registers, so a push in cycle M is visible at the output in M+1.
module obi_cmd_mgr_rsp_fifo
  import obi_cmd_mgr_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rsp_entry_t push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output rsp_entry_t data_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  rsp_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A simultaneous pop frees the slot the push needs when the FIFO is full.
  assign do_push = push_i && ((cnt_q != FullCnt) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= (wr_q == PtrLast) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == PtrLast) ? '0 : rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];

endmodule

// File: rtl/obi_cmd_mgr.sv
// OBI manager: converts a valid/ready command stream into OBI accesses and returns
// in-order responses. Optional response watchdog: define OBI_CMD_MGR_TIMEOUT_EN.
module obi_cmd_mgr
  import obi_cmd_mgr_pkg::*;
#(
  parameter type         obi_req_t      = obi_req_default_t,
  parameter type         obi_rsp_t      = obi_rsp_default_t,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned InflW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [InflW-1:0] MaxCnt  = InflW'(MaxOutstanding);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(MaxOutstanding - 1);

  logic                      req_q;
  logic [31:0]               addr_q;
  logic                      we_q;
  logic [3:0]                be_q;
  logic [31:0]               wdata_q;
  logic [AidW-1:0]           tag_q;
  logic [AidW-1:0]           exp_rid_q;
  logic [InflW-1:0]          inflight_q;
  logic [InflW-1:0]          pend_q;
  logic [MaxOutstanding-1:0] we_ring_q;
  logic [PtrW-1:0]           ring_wr_q;
  logic [PtrW-1:0]           ring_rd_q;

  logic       cmd_fire;
  logic       gnt_fire;
  logic       rv_ok;
  logic       rsp_fire;
  logic       timeout;
  rsp_entry_t push_entry;
  rsp_entry_t head_entry;

  assign gnt_fire    = req_q && obi_rsp_i.gnt;
  assign cmd_ready_o = (!req_q || obi_rsp_i.gnt) && (inflight_q < MaxCnt) && !timeout;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign rv_ok       = obi_rsp_i.rvalid && (pend_q != '0);
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;

  // A-channel holding register; a same-cycle grant lets the next command load directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (cmd_fire) begin
      req_q   <= 1'b1;
      addr_q  <= cmd_addr_i;
      we_q    <= cmd_we_i;
      be_q    <= cmd_be_i;
      wdata_q <= cmd_wdata_i;
    end else if (gnt_fire) begin
      req_q <= 1'b0;
    end
  end

  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = req_q;
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = we_q;
    obi_req_o.a.be    = be_q;
    obi_req_o.a.wdata = wdata_q;
    obi_req_o.a.aid   = tag_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      pend_q     <= '0;
      tag_q      <= '0;
      exp_rid_q  <= '0;
    end else begin
      case ({cmd_fire, rsp_fire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      case ({gnt_fire, rv_ok})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
      if (gnt_fire) tag_q <= tag_q + 1'b1;
      if (rv_ok) exp_rid_q <= exp_rid_q + 1'b1;
    end
  end

  // Remembers the direction of each granted access so write responses return zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_ring_q <= '0;
      ring_wr_q <= '0;
      ring_rd_q <= '0;
    end else begin
      if (gnt_fire) begin
        we_ring_q[ring_wr_q] <= we_q;
        ring_wr_q            <= (ring_wr_q == PtrLast) ? '0 : ring_wr_q + 1'b1;
      end
      if (rv_ok) begin
        ring_rd_q <= (ring_rd_q == PtrLast) ? '0 : ring_rd_q + 1'b1;
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.rdata = we_ring_q[ring_rd_q] ? 32'h0 : obi_rsp_i.r.rdata;
    push_entry.err   = obi_rsp_i.r.err || (obi_rsp_i.r.rid != exp_rid_q);
  end

  obi_cmd_mgr_rsp_fifo #(
    .Depth (MaxOutstanding)
  ) i_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rv_ok),
    .push_data_i (push_entry),
    .pop_i       (rsp_ready_i),
    .valid_o     (rsp_valid_o),
    .data_o      (head_entry)
  );

  assign rsp_rdata_o = head_entry.rdata;
  assign rsp_err_o   = head_entry.err;
  assign busy_o      = (inflight_q != '0);

`ifdef OBI_CMD_MGR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           timeout_q;

  // Counts cycles waiting on an outstanding response; the flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if ((pend_q == '0) || obi_rsp_i.rvalid) begin
      to_cnt_q <= '0;
    end else if (!timeout_q) begin
      if (to_cnt_q == ToW'(TimeoutCycles - 1)) timeout_q <= 1'b1;
      else to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TimeoutCycles);
  assign timeout = 1'b0;
`endif

  assign timeout_o = timeout;

endmodule

// File: tb/tb_obi_cmd_mgr.sv
// Directed bench for obi_cmd_mgr with a small OBI subordinate model that answers one
// cycle after each grant.
module tb_obi_cmd_mgr;
  import obi_cmd_mgr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic        cmd_we_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  obi_req_default_t obi_req;
  obi_rsp_default_t obi_rsp;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        timeout_o;

  logic        gnt_en;
  logic        rvalid_en;
  logic        corrupt_rid;
  logic        sub_rvalid = 1'b0;
  logic [31:0] sub_rdata  = 32'h0;
  logic        sub_err    = 1'b0;
  logic [3:0]  sub_rid    = 4'h0;
  logic        pend_v     = 1'b0;
  logic [31:0] pend_rdata = 32'h0;
  logic        pend_err   = 1'b0;
  logic [3:0]  pend_rid   = 4'h0;
  logic [31:0] reg04      = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  obi_cmd_mgr #(
    .MaxOutstanding (2),
    .TimeoutCycles  (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_we_i    (cmd_we_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_be_i    (cmd_be_i),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always_comb begin
    obi_rsp          = '0;
    obi_rsp.gnt      = gnt_en;
    obi_rsp.rvalid   = sub_rvalid;
    obi_rsp.r.rdata  = sub_rdata;
    obi_rsp.r.err    = sub_err;
    obi_rsp.r.rid    = sub_rid;
  end

  function automatic logic [31:0] sub_read(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h1000_0000;
      32'h0000_0004: return reg04;
      32'h0000_0FF0: return 32'hBADC_AB1E;
      default:       return 32'hA500_0000 | addr;
    endcase
  endfunction

  // Subordinate: grant seen in cycle G is answered with rvalid during cycle G+1.
  always @(negedge clk_i) begin
    sub_rvalid = pend_v && rvalid_en;
    sub_rdata  = pend_rdata;
    sub_err    = pend_err;
    sub_rid    = corrupt_rid ? (pend_rid ^ 4'h1) : pend_rid;
    pend_v     = 1'b0;
    if (obi_req.req && gnt_en) begin
      pend_v     = 1'b1;
      pend_rid   = obi_req.a.aid;
      pend_err   = (obi_req.a.addr == 32'h0000_0FF0);
      pend_rdata = sub_read(obi_req.a.addr);
      if (obi_req.a.we) begin
        if (obi_req.a.addr == 32'h4) reg04 = obi_req.a.wdata;
        pend_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] be);
    logic acc;
    acc = 1'b0;
    cmd_addr_i  = addr;
    cmd_we_i    = we;
    cmd_wdata_i = wdata;
    cmd_be_i    = be;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = cmd_ready_o;
      tick();
    end
    cmd_valid_i = 1'b0;
    check("accept", 32'(acc), 32'd1);
    check("bus_addr", obi_req.a.addr, addr);
    check("bus_be", 32'(obi_req.a.be), 32'(be));
    check("bus_we", 32'(obi_req.a.we), 32'(we));
  endtask

  task automatic wait_rsp(input logic [31:0] exp_rdata, input logic exp_err);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (rsp_valid_o) begin
        got = 1'b1;
        check("rsp_rdata", rsp_rdata_o, exp_rdata);
        check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      end
      tick();
    end
    check("rsp_arrived", 32'(got), 32'd1);
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    rsp_ready_i = 1'b1;
    issue(addr, we, wdata, be);
    wait_rsp(exp_rdata, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_we_i    = 1'b0;
    cmd_wdata_i = '0;
    cmd_be_i    = '0;
    rsp_ready_i = 1'b0;
    gnt_en      = 1'b1;
    rvalid_en   = 1'b1;
    corrupt_rid = 1'b0;
    repeat (3) tick();

    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_req", 32'(obi_req), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_err", 32'(rsp_err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0;

    // Write 0x1 to 0x04: req at N+1, response at N+3 with zero data.
    cmd_addr_i  = 32'h4;
    cmd_we_i    = 1'b1;
    cmd_wdata_i = 32'h1;
    cmd_be_i    = 4'hF;
    cmd_valid_i = 1'b1;
    check("t1_ready", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    check("t1_req", 32'(obi_req.req), 32'd1);
    check("t1_addr", obi_req.a.addr, 32'h4);
    check("t1_we", 32'(obi_req.a.we), 32'd1);
    check("t1_wdata", obi_req.a.wdata, 32'h1);
    check("t1_be", 32'(obi_req.a.be), 32'hF);
    check("t1_aid", 32'(obi_req.a.aid), 32'd0);
    tick();
    check("t1_req_dropped", 32'(obi_req.req), 32'd0);
    check("t1_no_rsp_yet", 32'(rsp_valid_o), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("t1_rsp_rdata", rsp_rdata_o, 32'h0);
    check("t1_rsp_err", 32'(rsp_err_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    rsp_ready_i = 1'b1;
    tick();
    check("t1_popped", 32'(rsp_valid_o), 32'd0);
    check("t1_idle", 32'(busy_o), 32'd0);

    do_txn(32'h0, 1'b0, 32'h0, 4'hF, 32'h1000_0000, 1'b0);
    do_txn(32'hFF0, 1'b0, 32'h0, 4'hF, 32'hBADC_AB1E, 1'b1);
    do_txn(32'h4, 1'b0, 32'h0, 4'h3, 32'h1, 1'b0);

    // Grant withheld for five cycles.
    gnt_en = 1'b0;
    issue(32'h8, 1'b0, 32'h5555_AAAA, 4'hC);
    for (int i = 0; i < 5; i++) begin
      check("t4_req_hold", 32'(obi_req.req), 32'd1);
      check("t4_addr_hold", obi_req.a.addr, 32'h8);
      check("t4_wdata_hold", obi_req.a.wdata, 32'h5555_AAAA);
      check("t4_ready_low", 32'(cmd_ready_o), 32'd0);
      tick();
    end
    gnt_en = 1'b1;
    #1;
    check("t4_ready_on_gnt", 32'(cmd_ready_o), 32'd1);
    wait_rsp(32'hA500_0008, 1'b0);

    // Outstanding limit with the response stream stalled.
    rsp_ready_i = 1'b0;
    issue(32'h10, 1'b0, 32'h0, 4'hF);
    issue(32'h14, 1'b0, 32'h0, 4'hF);
    cmd_addr_i  = 32'h18;
    cmd_we_i    = 1'b0;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_stall", 32'(cmd_ready_o), 32'd0);
      tick();
    end
    check("t5_head_valid", 32'(rsp_valid_o), 32'd1);
    check("t5_head_a", rsp_rdata_o, 32'hA500_0010);
    rsp_ready_i = 1'b1;
    tick();
    check("t5_freed", 32'(cmd_ready_o), 32'd1);
    check("t5_head_b", rsp_rdata_o, 32'hA500_0014);
    tick();
    cmd_valid_i = 1'b0;
    wait_rsp(32'hA500_0018, 1'b0);

    // rid mismatch flags an error; the next response realigns.
    corrupt_rid = 1'b1;
    do_txn(32'h0, 1'b0, 32'h0, 4'hF, 32'h1000_0000, 1'b1);
    corrupt_rid = 1'b0;
    do_txn(32'h0, 1'b0, 32'h0, 4'hF, 32'h1000_0000, 1'b0);

    // Reset while a request is waiting for its grant.
    gnt_en = 1'b0;
    issue(32'hC, 1'b0, 32'h0, 4'hF);
    rst_i = 1'b1;
    tick();
    check("t7_req_cleared", 32'(obi_req.req), 32'd0);
    check("t7_busy_cleared", 32'(busy_o), 32'd0);
    rst_i  = 1'b0;
    gnt_en = 1'b1;
    tick();

`ifdef OBI_CMD_MGR_TIMEOUT_EN
    rvalid_en = 1'b0;
    issue(32'h0, 1'b0, 32'h0, 4'hF);
    cnt = 0;
    while (!timeout_o && cnt < 100) begin
      tick();
      cnt++;
    end
    // One grant cycle plus sixteen cycles waiting on the response.
    check("t8_timeout_cycles", 32'(cnt), 32'd17);
    check("t8_timeout", 32'(timeout_o), 32'd1);
    check("t8_ready_blocked", 32'(cmd_ready_o), 32'd0);
    rst_i = 1'b1;
    tick();
    check("t8_timeout_cleared", 32'(timeout_o), 32'd0);
    rst_i     = 1'b0;
    rvalid_en = 1'b1;
    tick();
`else
    cnt = 0;
    check("t8_timeout_tied", 32'(timeout_o), 32'(cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
